// File: rtl/axi4_write_channel_arbiter.sv
// Purpose: round-robin sharing of one AXI4 slave AW/W channel pair among NO_OF_MASTERS masters;
//   W beats are routed in AW-grant order through a grant FIFO, and wlast is regenerated from awlen.
// Latency: AW 1 cycle (registered output stage); W 0 cycles (combinational routing from the FIFO head).
// Backpressure: the AW stage holds until s_awready; no grant while the grant FIFO is full;
//   s_wready is passed only to the master at the FIFO head, and all other m_wready stay low.
// Ports: m_aw*/m_w* are packed per-master request buses (master i owns slice i); s_aw*/s_w* form
//   the single slave port; err_wlast pulses on a master wlast that disagrees with awlen;
//   fifo_full reports a full grant FIFO.
module axi4_write_channel_arbiter #(
  parameter int NO_OF_MASTERS          = 2,
  parameter int ADDRESS_WIDTH          = 32,
  parameter int DATA_WIDTH             = 32,
  parameter int OUTSTANDING_FIFO_DEPTH = 16
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [NO_OF_MASTERS-1:0]                m_awvalid,
  output logic [NO_OF_MASTERS-1:0]                m_awready,
  input  logic [NO_OF_MASTERS*4-1:0]              m_awid,
  input  logic [NO_OF_MASTERS*ADDRESS_WIDTH-1:0]  m_awaddr,
  input  logic [NO_OF_MASTERS*8-1:0]              m_awlen,
  input  logic [NO_OF_MASTERS*3-1:0]              m_awsize,
  input  logic [NO_OF_MASTERS*2-1:0]              m_awburst,
  input  logic [NO_OF_MASTERS-1:0]                m_wvalid,
  output logic [NO_OF_MASTERS-1:0]                m_wready,
  input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0]     m_wdata,
  input  logic [NO_OF_MASTERS*(DATA_WIDTH/8)-1:0] m_wstrb,
  input  logic [NO_OF_MASTERS-1:0]                m_wlast,
  output logic                                    s_awvalid,
  input  logic                                    s_awready,
  output logic [3:0]                              s_awid,
  output logic [ADDRESS_WIDTH-1:0]                s_awaddr,
  output logic [7:0]                              s_awlen,
  output logic [2:0]                              s_awsize,
  output logic [1:0]                              s_awburst,
  output logic                                    s_wvalid,
  input  logic                                    s_wready,
  output logic [DATA_WIDTH-1:0]                   s_wdata,
  output logic [DATA_WIDTH/8-1:0]                 s_wstrb,
  output logic                                    s_wlast,
  output logic                                    err_wlast,
  output logic                                    fifo_full
);

  localparam int IDXW  = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;
  localparam int STRBW = DATA_WIDTH / 8;
  localparam int PTRW  = (OUTSTANDING_FIFO_DEPTH > 1) ? $clog2(OUTSTANDING_FIFO_DEPTH) : 1;
  localparam int CNTW  = $clog2(OUTSTANDING_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [7:0]      len;
  } grant_t;

  logic [IDXW-1:0]          rr_ptr;
  grant_t                   fifo_mem [OUTSTANDING_FIFO_DEPTH];
  logic [PTRW-1:0]          wr_ptr;
  logic [PTRW-1:0]          rd_ptr;
  logic [CNTW-1:0]          fifo_cnt;
  logic [7:0]               beat_cnt;
  grant_t                   head;
  logic                     fifo_empty;
  logic                     aw_free;
  logic                     capture;
  logic                     win_found;
  logic [IDXW-1:0]          win_idx;
  logic [IDXW-1:0]          cand;
  logic [3:0]               sel_id;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [7:0]               sel_len;
  logic [2:0]               sel_size;
  logic [1:0]               sel_burst;
  logic                     head_wlast;
  logic                     beat_last;
  logic                     w_hs;
  logic                     pop;

  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == PTRW'(OUTSTANDING_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNTW'(OUTSTANDING_FIFO_DEPTH));
  assign aw_free    = !s_awvalid || s_awready;
  assign head       = fifo_mem[rd_ptr];

  // Round robin: scan starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NO_OF_MASTERS; i++) begin
      cand = IDXW'((int'(rr_ptr) + i) % NO_OF_MASTERS);
      if (!win_found && m_awvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Fullness uses the registered count, so a same-cycle pop never frees a slot for a push.
  assign capture = aresetn && aw_free && !fifo_full && win_found;

  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    m_awready = '0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      if (win_idx == IDXW'(i)) begin
        sel_id       = m_awid[4*i +: 4];
        sel_addr     = m_awaddr[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
        sel_len      = m_awlen[8*i +: 8];
        sel_size     = m_awsize[3*i +: 3];
        sel_burst    = m_awburst[2*i +: 2];
        m_awready[i] = capture;
      end
    end
  end

  // W path follows the FIFO head only; a grant becomes visible the cycle after its push.
  always_comb begin
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    m_wready   = '0;
    head_wlast = 1'b0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      if (aresetn && !fifo_empty && head.idx == IDXW'(i)) begin
        s_wvalid    = m_wvalid[i];
        s_wdata     = m_wdata[DATA_WIDTH*i +: DATA_WIDTH];
        s_wstrb     = m_wstrb[STRBW*i +: STRBW];
        m_wready[i] = s_wready;
        head_wlast  = m_wlast[i];
      end
    end
  end

  // wlast toward the slave comes from the beat count; the master's wlast is only audited.
  assign beat_last = (beat_cnt == head.len);
  assign s_wlast   = aresetn && !fifo_empty && beat_last;
  assign w_hs      = s_wvalid && s_wready;
  assign err_wlast = w_hs && (head_wlast != beat_last);
  assign pop       = w_hs && beat_last;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_awvalid <= 1'b0;
      s_awid    <= '0;
      s_awaddr  <= '0;
      s_awlen   <= '0;
      s_awsize  <= '0;
      s_awburst <= '0;
      rr_ptr    <= IDXW'(NO_OF_MASTERS - 1);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      beat_cnt  <= '0;
    end else begin
      if (capture) begin
        s_awvalid <= 1'b1;
        s_awid    <= sel_id;
        s_awaddr  <= sel_addr;
        s_awlen   <= sel_len;
        s_awsize  <= sel_size;
        s_awburst <= sel_burst;
        rr_ptr    <= win_idx;
      end else if (aw_free) begin
        s_awvalid <= 1'b0;
      end
      if (capture) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      if (capture && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !capture) fifo_cnt <= fifo_cnt - 1'b1;
      if (w_hs) beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (capture) fifo_mem[wr_ptr] <= '{idx: win_idx, len: sel_len};
  end

endmodule

// File: tb/tb_axi4_write_channel_arbiter.sv
`timescale 1ns/1ps
module tb_axi4_write_channel_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int D  = 16;
  localparam int NB = 24;

  logic aclk = 1'b0;
  logic aresetn;
  logic [NM-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [NM*4-1:0]  m_awid;
  logic [NM*AW-1:0] m_awaddr;
  logic [NM*8-1:0]  m_awlen;
  logic [NM*3-1:0]  m_awsize;
  logic [NM*2-1:0]  m_awburst;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, err_wlast, fifo_full;
  logic [3:0] s_awid;
  logic [AW-1:0] s_awaddr;
  logic [7:0] s_awlen;
  logic [2:0] s_awsize;
  logic [1:0] s_awburst;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  axi4_write_channel_arbiter #(
    .NO_OF_MASTERS(NM), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING_FIFO_DEPTH(D)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .err_wlast(err_wlast), .fifo_full(fifo_full)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  // Per-master burst tables for the randomized traffic.
  int          len_tab  [NM][NB];
  logic [AW-1:0] addr_tab [NM][NB];
  logic [3:0]  id_tab   [NM][NB];
  logic [DW-1:0] seed   [NM];

  function automatic logic [DW-1:0] beat_data(input int m, input int b, input int k);
    return seed[m] ^ DW'((b << 8) | k);
  endfunction

  task automatic idle;
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0;
    s_awready = 1'b0; s_wready = 1'b0;
  endtask

  task automatic do_reset;
    idle;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset;
    idle;
    m_awvalid = 2'b11; m_wvalid = 2'b11; s_awready = 1'b1; s_wready = 1'b1;
    m_awaddr = {32'hDEAD_BEEF, 32'hCAFE_F00D}; m_awlen = 16'h0505; m_awid = 8'h7A;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk);
    @(negedge aclk);
    n_checks++; if (s_awvalid !== 1'b0) begin n_errors++; $display("FAIL reset_s_awvalid got %b exp 0", s_awvalid); end
    n_checks++; if ({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst} !== '0) begin n_errors++; $display("FAIL reset_aw_payload got %h exp 0", {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst}); end
    n_checks++; if (m_awready !== 2'b00) begin n_errors++; $display("FAIL reset_m_awready got %b exp 00", m_awready); end
    n_checks++; if (m_wready !== 2'b00) begin n_errors++; $display("FAIL reset_m_wready got %b exp 00", m_wready); end
    n_checks++; if ({s_wvalid, s_wlast, err_wlast, fifo_full} !== 4'b0000) begin n_errors++; $display("FAIL reset_w_flags got %b exp 0000", {s_wvalid, s_wlast, err_wlast, fifo_full}); end
    idle;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic test_rr_routing;
    m_awid = {4'd5, 4'd3}; m_awaddr = {32'h2000_0040, 32'h1000_0000}; m_awlen = {8'd0, 8'd3};
    m_awsize = {3'd2, 3'd2}; m_awburst = {2'b01, 2'b01};
    m_awvalid = 2'b11; s_awready = 1'b1;
    @(negedge aclk);
    n_checks++; if (m_awready !== 2'b01) begin n_errors++; $display("FAIL rr_first_grant got %b exp 01", m_awready); end
    n_checks++; if (s_awvalid !== 1'b0) begin n_errors++; $display("FAIL rr_awvalid_c1 got %b exp 0", s_awvalid); end
    @(posedge aclk); #1;
    m_awvalid = 2'b10;
    @(negedge aclk);
    n_checks++; if (m_awready !== 2'b10) begin n_errors++; $display("FAIL rr_second_grant got %b exp 10", m_awready); end
    n_checks++; if ({s_awvalid, s_awid, s_awaddr, s_awlen} !== {1'b1, 4'd3, 32'h1000_0000, 8'd3}) begin n_errors++; $display("FAIL rr_aw_m0 got %h exp %h", {s_awvalid, s_awid, s_awaddr, s_awlen}, {1'b1, 4'd3, 32'h1000_0000, 8'd3}); end
    @(posedge aclk); #1;
    m_awvalid = 2'b00;
    @(negedge aclk);
    n_checks++; if (m_awready !== 2'b00) begin n_errors++; $display("FAIL rr_no_grant got %b exp 00", m_awready); end
    n_checks++; if ({s_awvalid, s_awid, s_awaddr, s_awlen} !== {1'b1, 4'd5, 32'h2000_0040, 8'd0}) begin n_errors++; $display("FAIL rr_aw_m1 got %h exp %h", {s_awvalid, s_awid, s_awaddr, s_awlen}, {1'b1, 4'd5, 32'h2000_0040, 8'd0}); end
    @(posedge aclk); #1;
    @(negedge aclk);
    n_checks++; if (s_awvalid !== 1'b0) begin n_errors++; $display("FAIL rr_awvalid_drop got %b exp 0", s_awvalid); end
    // W: four beats from master 0 then one from master 1.
    @(posedge aclk); #1;
    m_wvalid = 2'b11; s_wready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic [DW-1:0] exp_d;
      logic [NM-1:0] exp_r;
      logic exp_l;
      m_wdata = {32'hB000_0000, 32'hA000_0000 + 32'(c)};
      m_wlast = {1'b1, c == 3};
      exp_d = (c < 4) ? 32'hA000_0000 + 32'(c) : 32'hB000_0000;
      exp_r = (c < 4) ? 2'b01 : 2'b10;
      exp_l = (c == 3) || (c == 4);
      @(negedge aclk);
      n_checks++; if ({s_wvalid, m_wready, s_wdata, s_wlast, err_wlast} !== {1'b1, exp_r, exp_d, exp_l, 1'b0}) begin n_errors++; $display("FAIL routing_beat%0d got v=%b rdy=%b d=%h last=%b err=%b exp v=1 rdy=%b d=%h last=%b err=0", c, s_wvalid, m_wready, s_wdata, s_wlast, err_wlast, exp_r, exp_d, exp_l); end
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    n_checks++; if ({s_wvalid, m_wready} !== 3'b000) begin n_errors++; $display("FAIL routing_empty got %b exp 000", {s_wvalid, m_wready}); end
    @(posedge aclk); #1;
  endtask

  task automatic test_aw_backpressure;
    do_reset;
    m_awaddr = {32'h2222_0000, 32'h1111_0000};
    m_awvalid = 2'b11; s_awready = 1'b0;
    @(negedge aclk);
    n_checks++; if (m_awready !== 2'b01) begin n_errors++; $display("FAIL bp_first_grant got %b exp 01", m_awready); end
    @(posedge aclk); #1;
    m_awaddr[31:0] = 32'h1111_1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      n_checks++; if ({s_awvalid, s_awaddr, m_awready} !== {1'b1, 32'h1111_0000, 2'b00}) begin n_errors++; $display("FAIL bp_hold_c%0d got v=%b a=%h rdy=%b exp v=1 a=11110000 rdy=00", c, s_awvalid, s_awaddr, m_awready); end
      @(posedge aclk); #1;
    end
    s_awready = 1'b1;
    @(negedge aclk);
    n_checks++; if (m_awready !== 2'b10) begin n_errors++; $display("FAIL bp_release_grant got %b exp 10", m_awready); end
    @(posedge aclk); #1;
    @(negedge aclk);
    n_checks++; if (s_awaddr !== 32'h2222_0000) begin n_errors++; $display("FAIL bp_next_addr got %h exp 22220000", s_awaddr); end
    @(posedge aclk); #1;
  endtask

  task automatic test_fifo_full;
    int grants;
    do_reset;
    grants = 0;
    m_awvalid = 2'b11; s_awready = 1'b1;
    for (int c = 0; c < D; c++) begin
      @(negedge aclk);
      if (m_awready != 2'b00) grants++;
      @(posedge aclk); #1;
    end
    n_checks++; if (grants !== D) begin n_errors++; $display("FAIL full_grant_count got %0d exp %0d", grants, D); end
    @(negedge aclk);
    n_checks++; if ({fifo_full, m_awready} !== 3'b100) begin n_errors++; $display("FAIL full_blocks got full=%b rdy=%b exp full=1 rdy=00", fifo_full, m_awready); end
    @(posedge aclk); #1;
    m_wvalid = 2'b01; m_wlast = 2'b01; s_wready = 1'b1;
    @(negedge aclk);
    n_checks++; if ({fifo_full, m_awready, s_wvalid, s_wlast} !== 5'b10011) begin n_errors++; $display("FAIL full_pop_cycle got %b exp 10011", {fifo_full, m_awready, s_wvalid, s_wlast}); end
    @(posedge aclk); #1;
    m_wvalid = 2'b00; s_wready = 1'b0;
    @(negedge aclk);
    n_checks++; if ({fifo_full, m_awready} !== 3'b001) begin n_errors++; $display("FAIL full_resume got full=%b rdy=%b exp full=0 rdy=01", fifo_full, m_awready); end
    @(posedge aclk); #1;
    @(negedge aclk);
    n_checks++; if (fifo_full !== 1'b1) begin n_errors++; $display("FAIL full_refill got %b exp 1", fifo_full); end
    @(posedge aclk); #1;
  endtask

  task automatic test_wlast_error;
    do_reset;
    m_awlen = 16'h0001; m_awvalid = 2'b01; s_awready = 1'b1;
    m_wvalid = 2'b01; m_wlast = 2'b01; s_wready = 1'b1; m_wdata = {32'h0, 32'hC000_0000};
    @(negedge aclk);
    n_checks++; if ({m_awready, s_wvalid, m_wready} !== 5'b01000) begin n_errors++; $display("FAIL werr_no_bypass got %b exp 01000", {m_awready, s_wvalid, m_wready}); end
    @(posedge aclk); #1;
    m_awvalid = 2'b00;
    @(negedge aclk);
    n_checks++; if ({s_wvalid, err_wlast, s_wlast, m_wready} !== 5'b11001) begin n_errors++; $display("FAIL werr_pulse got %b exp 11001", {s_wvalid, err_wlast, s_wlast, m_wready}); end
    @(posedge aclk); #1;
    m_wdata = {32'h0, 32'hC000_0001};
    @(negedge aclk);
    n_checks++; if ({s_wvalid, s_wlast, err_wlast, s_wdata} !== {3'b110, 32'hC000_0001}) begin n_errors++; $display("FAIL werr_beat2 got v=%b last=%b err=%b d=%h exp 1 1 0 c0000001", s_wvalid, s_wlast, err_wlast, s_wdata); end
    @(posedge aclk); #1;
    @(negedge aclk);
    n_checks++; if (s_wvalid !== 1'b0) begin n_errors++; $display("FAIL werr_drained got %b exp 0", s_wvalid); end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    m_awaddr = {32'h0000_2000, 32'h0000_1000}; m_awlen = 16'h0303;
    m_awvalid = 2'b01; s_awready = 1'b1;
    @(posedge aclk); #1;
    m_awvalid = 2'b00; m_wvalid = 2'b01; s_wready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      n_checks++; if ({s_wvalid, s_wlast} !== 2'b10) begin n_errors++; $display("FAIL mid_beat%0d got %b exp 10", c, {s_wvalid, s_wlast}); end
      @(posedge aclk); #1;
    end
    aresetn = 1'b0; m_awvalid = 2'b11;
    @(negedge aclk);
    n_checks++; if ({m_awready, s_wvalid} !== 3'b000) begin n_errors++; $display("FAIL mid_in_reset got %b exp 000", {m_awready, s_wvalid}); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++; if ({s_wvalid, s_awvalid, fifo_full, m_wready, m_awready} !== 7'b0000001) begin n_errors++; $display("FAIL mid_after_reset got %b exp 0000001", {s_wvalid, s_awvalid, fifo_full, m_wready, m_awready}); end
    @(posedge aclk); #1;
    m_awvalid = 2'b00; m_wvalid = 2'b00;
    @(negedge aclk);
    n_checks++; if ({s_awvalid, s_awaddr} !== {1'b1, 32'h0000_1000}) begin n_errors++; $display("FAIL mid_first_grant got v=%b a=%h exp v=1 a=00001000", s_awvalid, s_awaddr); end
    @(posedge aclk); #1;
  endtask

  task automatic test_random;
    int aw_b [NM];
    int w_b [NM];
    int w_beat [NM];
    bit awv [NM];
    bit wv [NM];
    int gq_m [$];
    int gq_b [$];
    int rr, hbeat, cyc, win, hm, hb;
    bit exp_awv, free, cap, done, hs;
    logic [3:0] e_id;
    logic [AW-1:0] e_addr;
    logic [7:0] e_len;
    logic [NM-1:0] exp_awready, exp_wready;
    logic exp_wvalid;
    do_reset;
    for (int m = 0; m < NM; m++) begin
      seed[m] = $urandom;
      aw_b[m] = 0; w_b[m] = 0; w_beat[m] = 0; awv[m] = 0; wv[m] = 0;
      for (int b = 0; b < NB; b++) begin
        len_tab[m][b] = $urandom_range(0, 7);
        addr_tab[m][b] = $urandom;
        id_tab[m][b] = 4'($urandom_range(0, 15));
      end
    end
    rr = NM - 1; exp_awv = 0; hbeat = 0; e_id = '0; e_addr = '0; e_len = '0;
    cyc = 0; done = 0; hm = 0; hb = 0;
    while (!done && cyc < 6000) begin
      for (int m = 0; m < NM; m++) begin
        if (!awv[m] && aw_b[m] < NB && $urandom_range(0, 2) != 0) awv[m] = 1;
        m_awvalid[m] = awv[m];
        if (aw_b[m] < NB) begin
          m_awid[4*m +: 4] = id_tab[m][aw_b[m]];
          m_awaddr[AW*m +: AW] = addr_tab[m][aw_b[m]];
          m_awlen[8*m +: 8] = 8'(len_tab[m][aw_b[m]]);
          m_awsize[3*m +: 3] = 3'd2;
          m_awburst[2*m +: 2] = 2'b01;
        end
        if (!wv[m] && w_b[m] < NB && $urandom_range(0, 3) != 0) wv[m] = 1;
        m_wvalid[m] = wv[m];
        if (w_b[m] < NB) begin
          m_wdata[DW*m +: DW] = beat_data(m, w_b[m], w_beat[m]);
          m_wstrb[SW*m +: SW] = SW'(w_beat[m] + w_b[m]);
          m_wlast[m] = (w_beat[m] == len_tab[m][w_b[m]]);
        end
      end
      s_awready = ($urandom_range(0, 3) != 0);
      s_wready = (((cyc / 128) % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      @(negedge aclk);
      // Reference: grant the first requester after the last winner when the output stage can take it.
      free = !exp_awv || s_awready;
      cap = free && (gq_m.size() < D) && (m_awvalid != '0);
      win = -1;
      for (int k = 1; k <= NM; k++) begin
        int c;
        c = (rr + k) % NM;
        if (win < 0 && m_awvalid[c]) win = c;
      end
      exp_awready = '0;
      if (cap) exp_awready[win] = 1'b1;
      exp_wvalid = 1'b0;
      exp_wready = '0;
      if (gq_m.size() > 0) begin
        hm = gq_m[0]; hb = gq_b[0];
        exp_wvalid = m_wvalid[hm];
        exp_wready[hm] = s_wready;
      end
      n_checks++; if (m_awready !== exp_awready) begin n_errors++; $display("FAIL rnd_awready cyc=%0d got %b exp %b", cyc, m_awready, exp_awready); end
      n_checks++; if (s_awvalid !== exp_awv) begin n_errors++; $display("FAIL rnd_awvalid cyc=%0d got %b exp %b", cyc, s_awvalid, exp_awv); end
      if (exp_awv) begin
        n_checks++; if ({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst} !== {e_id, e_addr, e_len, 3'd2, 2'b01}) begin n_errors++; $display("FAIL rnd_aw_payload cyc=%0d got %h exp %h", cyc, {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst}, {e_id, e_addr, e_len, 3'd2, 2'b01}); end
      end
      n_checks++; if (fifo_full !== (gq_m.size() == D)) begin n_errors++; $display("FAIL rnd_fifo_full cyc=%0d got %b exp %b", cyc, fifo_full, gq_m.size() == D); end
      n_checks++; if ({s_wvalid, m_wready} !== {exp_wvalid, exp_wready}) begin n_errors++; $display("FAIL rnd_w_route cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b", cyc, s_wvalid, m_wready, exp_wvalid, exp_wready); end
      hs = (gq_m.size() > 0) && exp_wvalid && s_wready;
      if (hs) begin
        n_checks++; if ({s_wdata, s_wstrb, s_wlast, err_wlast} !== {beat_data(hm, hb, hbeat), SW'(hbeat + hb), hbeat == len_tab[hm][hb], 1'b0}) begin n_errors++; $display("FAIL rnd_w_beat cyc=%0d m=%0d b=%0d k=%0d got d=%h s=%h last=%b err=%b exp d=%h last=%b", cyc, hm, hb, hbeat, s_wdata, s_wstrb, s_wlast, err_wlast, beat_data(hm, hb, hbeat), hbeat == len_tab[hm][hb]); end
        wv[hm] = 0;
        if (hbeat == len_tab[hm][hb]) begin
          w_b[hm]++; w_beat[hm] = 0;
          void'(gq_m.pop_front()); void'(gq_b.pop_front());
          hbeat = 0;
        end else begin
          w_beat[hm]++;
          hbeat++;
        end
      end
      if (cap) begin
        e_id = id_tab[win][aw_b[win]];
        e_addr = addr_tab[win][aw_b[win]];
        e_len = 8'(len_tab[win][aw_b[win]]);
        exp_awv = 1;
        gq_m.push_back(win); gq_b.push_back(aw_b[win]);
        aw_b[win]++; awv[win] = 0; rr = win;
      end else if (free) begin
        exp_awv = 0;
      end
      cyc++;
      done = 1;
      for (int m = 0; m < NM; m++) if (w_b[m] < NB) done = 0;
      @(posedge aclk); #1;
    end
    n_checks++; if (!done) begin n_errors++; $display("FAIL rnd_timeout got cycles=%0d exp completion before 6000", cyc); end
    idle;
  endtask

  initial begin
    aresetn = 1'b0;
    idle;
    test_reset;
    test_rr_routing;
    test_aw_backpressure;
    test_fifo_full;
    test_wlast_error;
    test_reset_mid_burst;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4_write_channel_arbiter.md
Name: axi4_write_channel_arbiter

Overview:
- Shares one AXI4 slave write-address (AW) and write-data (W) channel pair between NO_OF_MASTERS requesters.
- AW: round-robin arbitration into a registered output stage.
- W: beats routed strictly in AW-grant order via an internal grant FIFO of depth OUTSTANDING_FIFO_DEPTH; burst length enforced by a beat counter.
- Sits between master-side agent interfaces and a single slave port in the multi-master AXI4 environment. B channel out of scope.

Parameters:
- NO_OF_MASTERS, 2, number of requesting masters (1..16)
- ADDRESS_WIDTH, 32, AW address width
- DATA_WIDTH, 32, W data width; strobe width DATA_WIDTH/8
- OUTSTANDING_FIFO_DEPTH, 16, grant FIFO entries (power of 2)

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  synchronous active-low reset
- m_awvalid  in  NO_OF_MASTERS  per-master AW valid
- m_awready  out  NO_OF_MASTERS  per-master AW ready
- m_awid  in  NO_OF_MASTERS*4  packed, master i at [4i+3:4i]
- m_awaddr  in  NO_OF_MASTERS*ADDRESS_WIDTH  packed
- m_awlen  in  NO_OF_MASTERS*8  packed
- m_awsize  in  NO_OF_MASTERS*3  packed
- m_awburst  in  NO_OF_MASTERS*2  packed
- m_wvalid  in  NO_OF_MASTERS  per-master W valid
- m_wready  out  NO_OF_MASTERS  per-master W ready
- m_wdata  in  NO_OF_MASTERS*DATA_WIDTH  packed
- m_wstrb  in  NO_OF_MASTERS*(DATA_WIDTH/8)  packed
- m_wlast  in  NO_OF_MASTERS  per-master wlast
- s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst  out  1/4/ADDRESS_WIDTH/8/3/2  slave AW
- s_awready  in  1  slave AW ready
- s_wvalid, s_wdata, s_wstrb, s_wlast  out  1/DATA_WIDTH/DATA_WIDTH/8/1  slave W
- s_wready  in  1  slave W ready
- err_wlast  out  1  one-cycle pulse on wlast mismatch
- fifo_full  out  1  grant FIFO full

Behaviour:
- Reset (aresetn=0 at posedge): s_awvalid=0; all s_aw* payload=0; m_awready=0; m_wready=0; s_wvalid=0; s_wlast=0; err_wlast=0; FIFO empty; beat counter=0; rr pointer=NO_OF_MASTERS-1, so master 0 wins first. Reset mid-burst discards all queued grants and partial bursts.
- AW output register "free" when s_awvalid=0 or (s_awvalid && s_awready).
- Capture: if free, FIFO not full, and any m_awvalid set:
  - Winner = first requesting index after rr pointer, modulo NO_OF_MASTERS.
  - m_awready[winner]=1 combinationally that cycle; all other m_awready=0.
  - On the clock edge: payload registered to s_aw*; s_awvalid=1; {winner, awlen} pushed to FIFO; rr pointer=winner.
- AW latency: 1 cycle. Back-to-back capture allowed while s_awready=1, giving 1 AW/cycle throughput.
- s_awvalid/payload held stable until s_awready. If free but nothing captured, s_awvalid drops to 0.
- FIFO full: no capture, m_awready all 0. A pop in the same cycle does not enable a push, so full state is judged on registered count.
- W routing is combinational, zero latency, driven by FIFO head (idx, len):
  - FIFO non-empty: s_wvalid=m_wvalid[idx]; s_wdata/s_wstrb from idx; m_wready[idx]=s_wready; other m_wready=0.
  - FIFO empty: s_wvalid=0, all m_wready=0. W beats arriving before their AW stall.
- W data may pass the slave in the same cycle its AW is captured into the FIFO? No: head is visible the cycle after push.
- Beat counter (8 bit) increments on each s_wvalid && s_wready.
  - s_wlast=(counter==len), generated internally and never taken from the master.
  - On the last beat: counter←0 and FIFO pops.
- err_wlast pulses 1 on any W handshake where m_wlast[idx] != (counter==len). Routing is unaffected.
- Simultaneous push and pop: count unchanged, both take effect.
- Pointer wrap: modulo OUTSTANDING_FIFO_DEPTH.
- fifo_full=(count==OUTSTANDING_FIFO_DEPTH).

Test Plan:
- Reset, then m_awvalid=2'b11, s_awready=1 -> master 0 captured cycle 1, master 1 cycle 2; s_awaddr follows each master's address 1 cycle after its m_awready; FIFO order {0,1}.
- Master 0 awlen=3, master 1 awlen=0; both wvalid held, s_wready=1 -> 4 beats from master 0 (s_wlast on beat 4), then 1 beat from master 1 with s_wlast=1; FIFO empty after.
- s_awready=0 for 5 cycles with both masters requesting -> s_awvalid and payload stable 5 cycles; no further m_awready pulses.
- 16 AWs granted, s_wready=0 -> fifo_full=1, m_awready=0 on 17th request. One burst completes -> capture resumes next cycle.
- Master 0 awlen=1 but drives m_wlast=1 on beat 1 -> err_wlast=1 that cycle; s_wlast=0; burst continues to beat 2.
- aresetn=0 mid-burst (beat 2 of 4) -> next cycle s_wvalid=0, s_awvalid=0, FIFO empty; first post-reset grant goes to master 0.
